decode_ctrl_pipe: RTL and testbench
===================================

# decode_ctrl_pipe

Parametrised decode-stage control unit with a registered ID/EX control stage. It decodes the 32-bit instruction in D, raises an illegal-instruction flag, optionally decodes the M extension and RV64 word ops, and stalls decode for multi-cycle multiply/divide. It sits between the fetch/decode register and the execute stage, and replaces the purely combinational control decoder in the pipelined core.

## Interface

Parameters:
- XLEN, 32, datapath width; legal values are 32 or 64. At 64, OP-32 (0111011) and OP-IMM-32 (0011011) decode as legal and set wordOpE.
- MD_LATENCY, 4, number of cycles decode is held off after an M-extension op is accepted; must be ≥1.

Ports (one clock, `clk`; reset `rst_n` is asynchronous and active-low):
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- instrD  in  32  instruction in decode
- validD  in  1  instrD holds a real instruction
- readyD  out  1  decode may hand over an instruction this cycle
- stallE  in  1  execute cannot accept; hold the E register
- flushE  in  1  insert a bubble into E
- validE  out  1  E register holds an instruction
- regWriteE, memWriteE, jumpE, branchE, aluSrcE, aluSrcAE  out  1 each  registered controls; aluSrcAE selects PC as ALU operand A
- aluOpE  out  2  00 add, 01 branch compare, 10 funct-decoded, 11 mul/div
- resultSrcE  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate
- immSrcE  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- mulDivE, wordOpE, illegalE  out  1 each  M-extension op, RV64 word op, undecodable instruction

## Operation

- Accept when validD && readyD. readyD = rst_n && state==IDLE && !stallE.
- Decode, by opcode:
  - R-type: regWrite, aluOp 10.
  - I-ALU: regWrite, aluSrc, aluOp 10, imm I.
  - Load: regWrite, aluSrc, resultSrc 01, imm I.
  - Store: memWrite, aluSrc, imm S.
  - Branch: branch, aluOp 01, imm B.
  - JALR: regWrite, jump, aluSrc, resultSrc 10, imm I.
  - JAL: regWrite, jump, resultSrc 10, imm J.
  - LUI: regWrite, resultSrc 11, imm U.
  - AUIPC: regWrite, aluSrc, aluSrcA, imm U.
- R-type with funct7 0000001: mulDiv=1, aluOp 11 when M is compiled in; otherwise illegal.
- Unknown opcode, or a word op at XLEN=32: illegalE=1 with validE=1, and regWrite, memWrite, jump and branch all 0.
- FSM:
  - IDLE→MD_BUSY on accepting a mulDiv op; counter loads MD_LATENCY-1.
  - MD_BUSY: counter decrements each cycle; →IDLE the cycle after it reads 0.
  - flushE in MD_BUSY→IDLE immediately.
- E register update priority: flushE (validE←0, all controls←0) > stallE (hold) > accept (load) > otherwise bubble.
- flushE together with a valid D instruction: the instruction is dropped, not loaded.

## Timing

- Reset: every output 0, state IDLE, counter 0. readyD is 0 while rst_n is low.
- Latency: an instruction accepted in cycle N appears on the E outputs in cycle N+1.
- A mulDiv op accepted in cycle N holds readyD low for cycles N+1 … N+MD_LATENCY. readyD returns in N+MD_LATENCY+1 if stallE is low.
- E shows the mulDiv op for one cycle, then bubbles while busy unless stallE holds it.
- The counter keeps running under stallE.
- Reset asserted mid-MD_BUSY returns to IDLE asynchronously.

## Configuration

- RV_M_EXT_EN defined: funct7 0000001 decodes as mul/div; the MD_BUSY state and counter exist.
- RV_M_EXT_EN undefined: those encodings are illegal, mulDivE is tied 0, and the FSM reduces to IDLE only.

## Structure

- Shared package `riscv_pkg`:
  - opcode constants;
  - aluOp, resultSrc and immSrc enums;
  - a control-bundle struct used for the E register.
- Sub-module `main_decoder`: pure combinational opcode→control-bundle decode. The top level holds the FSM, counter and E register.

## Test plan

- add x3,x1,x2 (0x002081B3), validD=1 → next cycle: validE=1, regWriteE=1, aluOpE=10, aluSrcE=0.
- lw x3,0(x1) (0x0000A183) → resultSrcE=01, aluSrcE=1, immSrcE=000. Then auipc (0x00000197) → aluSrcAE=1, immSrcE=011.
- mul x3,x1,x2 (0x022081B3), MD_LATENCY=4, RV_M_EXT_EN defined → mulDivE=1 for one cycle, readyD low for exactly 4 cycles. Without the macro → illegalE=1, readyD never drops.
- 0x00000000 → illegalE=1, regWriteE=0, memWriteE=0.
- stallE held 3 cycles with E loaded → E outputs unchanged. flushE asserted with validD=1 → validE=0 next cycle.
- addw (0x002081BB): XLEN=64 → wordOpE=1, regWriteE=1; XLEN=32 → illegalE=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode constants, control-field encodings and the ID/EX control bundle
// shared by the decode-stage control unit and its main decoder.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_REG      = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_32       = 7'b0111011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10,
        ALU_MULDIV = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic        alu_src_a;
        alu_op_t     alu_op;
        result_src_t result_src;
        imm_src_t    imm_src;
        logic        mul_div;
        logic        word_op;
        logic        illegal;
    } ctrl_t;

    // All-zero bundle: what a bubble or a reset looks like in the E stage.
    function automatic ctrl_t ctrl_nop();
        ctrl_t c;
        c.reg_write  = 1'b0;
        c.mem_write  = 1'b0;
        c.jump       = 1'b0;
        c.branch     = 1'b0;
        c.alu_src    = 1'b0;
        c.alu_src_a  = 1'b0;
        c.alu_op     = ALU_ADD;
        c.result_src = RES_ALU;
        c.imm_src    = IMM_I;
        c.mul_div    = 1'b0;
        c.word_op    = 1'b0;
        c.illegal    = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/decode_ctrl_pipe_main_decoder.sv
// main_decoder: purely combinational opcode/funct7 to control-bundle decode.
// Defining RV_M_EXT_EN makes funct7 0000001 on OP/OP-32 decode as mul/div instead of illegal.
module main_decoder
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
)
(
    input  logic [6:0] opcode,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl
);

    localparam bit WIDE = (XLEN == 64);

    logic is_md;

    always_comb begin
        ctrl  = ctrl_nop();
        is_md = (funct7 == FUNCT7_MULDIV);
        case (opcode)
            OP_REG, OP_32: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
                ctrl.word_op   = (opcode == OP_32);
                if (is_md) begin
`ifdef RV_M_EXT_EN
                    ctrl.mul_div = 1'b1;
                    ctrl.alu_op  = ALU_MULDIV;
`else
                    ctrl.illegal = 1'b1;
`endif
                end
                if (opcode == OP_32 && !WIDE) ctrl.illegal = 1'b1;
            end
            OP_IMM, OP_IMM_32: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
                ctrl.imm_src   = IMM_I;
                ctrl.word_op   = (opcode == OP_IMM_32);
                if (opcode == OP_IMM_32 && !WIDE) ctrl.illegal = 1'b1;
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.imm_src    = IMM_I;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_S;
            end
            OP_BRANCH: begin
                ctrl.branch  = 1'b1;
                ctrl.alu_op  = ALU_BRANCH;
                ctrl.imm_src = IMM_B;
            end
            OP_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.imm_src    = IMM_I;
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.imm_src    = IMM_J;
            end
            OP_LUI: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_IMM;
                ctrl.imm_src    = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_src_a = 1'b1;
                ctrl.imm_src   = IMM_U;
            end
            default: ctrl.illegal = 1'b1;
        endcase

        // An undecodable instruction must not cause any architectural side effect downstream.
        if (ctrl.illegal) begin
            ctrl         = ctrl_nop();
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: decode-stage control with a registered ID/EX control stage and mul/div hold-off.
// Optional M extension (MD_BUSY state and latency counter) is built when RV_M_EXT_EN is defined.
module decode_ctrl_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MD_LATENCY = 4
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instrD,
    input  logic        validD,
    output logic        readyD,
    input  logic        stallE,
    input  logic        flushE,
    output logic        validE,
    output logic        regWriteE,
    output logic        memWriteE,
    output logic        jumpE,
    output logic        branchE,
    output logic        aluSrcE,
    output logic        aluSrcAE,
    output logic [1:0]  aluOpE,
    output logic [1:0]  resultSrcE,
    output logic [2:0]  immSrcE,
    output logic        mulDivE,
    output logic        wordOpE,
    output logic        illegalE
);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t state;
    ctrl_t  dec_ctrl;
    ctrl_t  e_ctrl;
    logic   e_valid;
    logic   accept;
    logic   unused_bits;

    // Register and funct3 fields carry no control information at this stage.
    assign unused_bits = ^instrD[24:7];

    main_decoder #(
        .XLEN (XLEN)
    ) u_main_decoder (
        .opcode (instrD[6:0]),
        .funct7 (instrD[31:25]),
        .ctrl   (dec_ctrl)
    );

    assign readyD = rst_n && (state == IDLE) && !stallE;
    assign accept = validD && readyD;

`ifdef RV_M_EXT_EN
    localparam int CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

    logic [CNT_W-1:0] md_cnt;

    // Decode is held off while the counter runs down; it keeps counting even under stallE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            md_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !flushE && dec_ctrl.mul_div) begin
                        state  <= MD_BUSY;
                        md_cnt <= CNT_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (flushE) begin
                        state  <= IDLE;
                        md_cnt <= '0;
                    end else if (md_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        md_cnt <= md_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    md_cnt <= '0;
                end
            endcase
        end
    end
`else
    localparam int unused_md_latency = MD_LATENCY;

    assign state = IDLE;
`endif

    // ID/EX control register: flush beats stall, stall beats a new instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid <= 1'b0;
            e_ctrl  <= ctrl_nop();
        end else if (flushE) begin
            e_valid <= 1'b0;
            e_ctrl  <= ctrl_nop();
        end else if (stallE) begin
            e_valid <= e_valid;
            e_ctrl  <= e_ctrl;
        end else if (accept) begin
            e_valid <= 1'b1;
            e_ctrl  <= dec_ctrl;
        end else begin
            e_valid <= 1'b0;
            e_ctrl  <= ctrl_nop();
        end
    end

    assign validE     = e_valid;
    assign regWriteE  = e_ctrl.reg_write;
    assign memWriteE  = e_ctrl.mem_write;
    assign jumpE      = e_ctrl.jump;
    assign branchE    = e_ctrl.branch;
    assign aluSrcE    = e_ctrl.alu_src;
    assign aluSrcAE   = e_ctrl.alu_src_a;
    assign aluOpE     = e_ctrl.alu_op;
    assign resultSrcE = e_ctrl.result_src;
    assign immSrcE    = e_ctrl.imm_src;
    assign mulDivE    = e_ctrl.mul_div;
    assign wordOpE    = e_ctrl.word_op;
    assign illegalE   = e_ctrl.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: scoreboard bench for decode_ctrl_pipe at XLEN=32 and XLEN=64.
// Expectations for mul/div follow RV_M_EXT_EN when it is defined for the build.
module tb_decode_ctrl_pipe;

    localparam int MDL = 4;
`ifdef RV_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    // Packed E view: {v,rw,mw,j,b,as,asa}, aluOp, resultSrc, immSrc, {md,wo,ill}
    localparam logic [16:0] E_BUB    = 17'd0;
    localparam logic [16:0] E_ADD    = {7'b1100000, 2'b10, 2'b00, 3'b000, 3'b000};
    localparam logic [16:0] E_ADDI   = {7'b1100010, 2'b10, 2'b00, 3'b000, 3'b000};
    localparam logic [16:0] E_LW     = {7'b1100010, 2'b00, 2'b01, 3'b000, 3'b000};
    localparam logic [16:0] E_SW     = {7'b1010010, 2'b00, 2'b00, 3'b001, 3'b000};
    localparam logic [16:0] E_BEQ    = {7'b1000100, 2'b01, 2'b00, 3'b010, 3'b000};
    localparam logic [16:0] E_JALR   = {7'b1101010, 2'b00, 2'b10, 3'b000, 3'b000};
    localparam logic [16:0] E_JAL    = {7'b1101000, 2'b00, 2'b10, 3'b100, 3'b000};
    localparam logic [16:0] E_LUI    = {7'b1100000, 2'b00, 2'b11, 3'b011, 3'b000};
    localparam logic [16:0] E_AUIPC  = {7'b1100011, 2'b00, 2'b00, 3'b011, 3'b000};
    localparam logic [16:0] E_ILL    = {7'b1000000, 2'b00, 2'b00, 3'b000, 3'b001};
    localparam logic [16:0] E_MULM   = {7'b1100000, 2'b11, 2'b00, 3'b000, 3'b100};
    localparam logic [16:0] E_ADDW   = {7'b1100000, 2'b10, 2'b00, 3'b000, 3'b010};
    localparam logic [16:0] E_ADDIW  = {7'b1100010, 2'b10, 2'b00, 3'b000, 3'b010};
    localparam logic [16:0] E_MUL    = M_EN ? E_MULM : E_ILL;

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_LW  = 32'h0000A183;
    localparam logic [31:0] I_MUL = 32'h022081B3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instrD;
    logic        validD, stallE, flushE;

    logic        readyD, validE, regWriteE, memWriteE, jumpE, branchE, aluSrcE, aluSrcAE;
    logic [1:0]  aluOpE, resultSrcE;
    logic [2:0]  immSrcE;
    logic        mulDivE, wordOpE, illegalE;

    logic        ready_64, valid_64, reg_write_64, mem_write_64, jump_64, branch_64;
    logic        alu_src_64, alu_src_a_64, mul_div_64, word_op_64, illegal_64;
    logic [1:0]  alu_op_64, result_src_64;
    logic [2:0]  imm_src_64;

    int          compared   = 0;
    int          mismatched = 0;
    logic [16:0] sb[$];
    logic [16:0] sb64[$];
    logic [16:0] want;

    wire [16:0] e_vec = {validE, regWriteE, memWriteE, jumpE, branchE, aluSrcE, aluSrcAE,
                         aluOpE, resultSrcE, immSrcE, mulDivE, wordOpE, illegalE};
    wire [16:0] e_vec64 = {valid_64, reg_write_64, mem_write_64, jump_64, branch_64, alu_src_64,
                           alu_src_a_64, alu_op_64, result_src_64, imm_src_64, mul_div_64,
                           word_op_64, illegal_64};

    always #5 clk = ~clk;

    decode_ctrl_pipe #(.XLEN(32), .MD_LATENCY(MDL)) dut (
        .clk(clk), .rst_n(rst_n), .instrD(instrD), .validD(validD), .readyD(readyD),
        .stallE(stallE), .flushE(flushE), .validE(validE), .regWriteE(regWriteE),
        .memWriteE(memWriteE), .jumpE(jumpE), .branchE(branchE), .aluSrcE(aluSrcE),
        .aluSrcAE(aluSrcAE), .aluOpE(aluOpE), .resultSrcE(resultSrcE), .immSrcE(immSrcE),
        .mulDivE(mulDivE), .wordOpE(wordOpE), .illegalE(illegalE)
    );

    decode_ctrl_pipe #(.XLEN(64), .MD_LATENCY(MDL)) dut64 (
        .clk(clk), .rst_n(rst_n), .instrD(instrD), .validD(validD), .readyD(ready_64),
        .stallE(stallE), .flushE(flushE), .validE(valid_64), .regWriteE(reg_write_64),
        .memWriteE(mem_write_64), .jumpE(jump_64), .branchE(branch_64), .aluSrcE(alu_src_64),
        .aluSrcAE(alu_src_a_64), .aluOpE(alu_op_64), .resultSrcE(result_src_64),
        .immSrcE(imm_src_64), .mulDivE(mul_div_64), .wordOpE(word_op_64), .illegalE(illegal_64)
    );

    task automatic test_reset();
        rst_n = 1'b0; validD = 1'b0; stallE = 1'b0; flushE = 1'b0; instrD = 32'h0;
        repeat (2) @(negedge clk);
        compared++;
        if (e_vec !== E_BUB) begin
            mismatched++; $display("[TB] FAIL reset_e: got %b want %b", e_vec, E_BUB);
        end
        compared++;
        if (readyD !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_ready: got %b want 0", readyD);
        end
        rst_n = 1'b1;
        #1;
        compared++;
        if (readyD !== 1'b1) begin
            mismatched++; $display("[TB] FAIL release_ready: got %b want 1", readyD);
        end
    endtask

    task automatic test_decode();
        logic [31:0] instrs [11];
        logic [16:0] exps   [11];
        instrs = '{I_ADD, I_LW, 32'h00000197, 32'h0030A023, 32'h00208063, 32'h008000EF,
                   32'h000080E7, 32'h000011B7, 32'h00108093, 32'h00000000, 32'h002081BB};
        exps   = '{E_ADD, E_LW, E_AUIPC, E_SW, E_BEQ, E_JAL,
                   E_JALR, E_LUI, E_ADDI, E_ILL, E_ILL};
        for (int i = 0; i < 11; i++) begin
            instrD = instrs[i]; validD = 1'b1;
            #1;
            compared++;
            if (readyD !== 1'b1) begin
                mismatched++; $display("[TB] FAIL decode_ready[%0d]: got %b want 1", i, readyD);
            end
            sb.push_back(exps[i]);
            @(negedge clk);
            want = sb.pop_front();
            compared++;
            if (e_vec !== want) begin
                mismatched++;
                $display("[TB] FAIL decode[%0d] %h: got %b want %b", i, instrs[i], e_vec, want);
            end
        end
        validD = 1'b0;
        sb.push_back(E_BUB);
        @(negedge clk);
        want = sb.pop_front();
        compared++;
        if (e_vec !== want) begin
            mismatched++; $display("[TB] FAIL idle_bubble: got %b want %b", e_vec, want);
        end
    endtask

    task automatic test_muldiv();
        int busy;
        int low_cycles;
        logic exp_ready;
        low_cycles = 0;
        instrD = I_MUL; validD = 1'b1;
        sb.push_back(E_MUL);
        @(negedge clk);
        instrD = I_ADD;
        busy = M_EN ? MDL : 0;
        for (int k = 1; k <= MDL + 1; k++) begin
            want = sb.pop_front();
            compared++;
            if (e_vec !== want) begin
                mismatched++; $display("[TB] FAIL muldiv_e[%0d]: got %b want %b", k, e_vec, want);
            end
            exp_ready = (busy == 0);
            if (readyD === 1'b0) low_cycles++;
            compared++;
            if (readyD !== exp_ready) begin
                mismatched++;
                $display("[TB] FAIL muldiv_ready[%0d]: got %b want %b", k, readyD, exp_ready);
            end
            sb.push_back(exp_ready ? E_ADD : E_BUB);
            if (busy > 0) busy--;
            @(negedge clk);
        end
        want = sb.pop_front();
        compared++;
        if (e_vec !== want) begin
            mismatched++; $display("[TB] FAIL muldiv_after: got %b want %b", e_vec, want);
        end
        compared++;
        if (low_cycles != (M_EN ? MDL : 0)) begin
            mismatched++;
            $display("[TB] FAIL muldiv_low_cycles: got %0d want %0d", low_cycles, M_EN ? MDL : 0);
        end
        validD = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stall();
        instrD = I_LW; validD = 1'b1;
        sb.push_back(E_LW);
        @(negedge clk);
        want = sb.pop_front();
        compared++;
        if (e_vec !== want) begin
            mismatched++; $display("[TB] FAIL stall_load: got %b want %b", e_vec, want);
        end
        instrD = I_ADD; stallE = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            compared++;
            if (readyD !== 1'b0) begin
                mismatched++; $display("[TB] FAIL stall_ready[%0d]: got %b want 0", k, readyD);
            end
            sb.push_back(E_LW);
            @(negedge clk);
            want = sb.pop_front();
            compared++;
            if (e_vec !== want) begin
                mismatched++; $display("[TB] FAIL stall_hold[%0d]: got %b want %b", k, e_vec, want);
            end
        end
        stallE = 1'b0;
        sb.push_back(E_ADD);
        @(negedge clk);
        want = sb.pop_front();
        compared++;
        if (e_vec !== want) begin
            mismatched++; $display("[TB] FAIL stall_release: got %b want %b", e_vec, want);
        end
        validD = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush();
        instrD = I_ADD; validD = 1'b1;
        sb.push_back(E_ADD);
        @(negedge clk);
        want = sb.pop_front();
        compared++;
        if (e_vec !== want) begin
            mismatched++; $display("[TB] FAIL flush_pre: got %b want %b", e_vec, want);
        end
        instrD = I_LW; flushE = 1'b1;
        sb.push_back(E_BUB);
        @(negedge clk);
        want = sb.pop_front();
        compared++;
        if (e_vec !== want) begin
            mismatched++; $display("[TB] FAIL flush_drop: got %b want %b", e_vec, want);
        end
        flushE = 1'b0; instrD = I_MUL;
        sb.push_back(E_MUL);
        @(negedge clk);
        want = sb.pop_front();
        compared++;
        if (e_vec !== want) begin
            mismatched++; $display("[TB] FAIL flush_mul: got %b want %b", e_vec, want);
        end
        validD = 1'b0; flushE = 1'b1;
        @(negedge clk);
        flushE = 1'b0;
        #1;
        compared++;
        if (readyD !== 1'b1) begin
            mismatched++; $display("[TB] FAIL flush_busy_ready: got %b want 1", readyD);
        end
        compared++;
        if (e_vec !== E_BUB) begin
            mismatched++; $display("[TB] FAIL flush_busy_e: got %b want %b", e_vec, E_BUB);
        end
        @(negedge clk);
    endtask

    task automatic test_wordop();
        instrD = 32'h002081BB; validD = 1'b1;
        sb.push_back(E_ILL);
        sb64.push_back(E_ADDW);
        @(negedge clk);
        instrD = 32'h0010809B;
        want = sb.pop_front();
        compared++;
        if (e_vec !== want) begin
            mismatched++; $display("[TB] FAIL addw_x32: got %b want %b", e_vec, want);
        end
        want = sb64.pop_front();
        compared++;
        if (e_vec64 !== want) begin
            mismatched++; $display("[TB] FAIL addw_x64: got %b want %b", e_vec64, want);
        end
        sb.push_back(E_ILL);
        sb64.push_back(E_ADDIW);
        @(negedge clk);
        validD = 1'b0;
        want = sb.pop_front();
        compared++;
        if (e_vec !== want) begin
            mismatched++; $display("[TB] FAIL addiw_x32: got %b want %b", e_vec, want);
        end
        want = sb64.pop_front();
        compared++;
        if (e_vec64 !== want) begin
            mismatched++; $display("[TB] FAIL addiw_x64: got %b want %b", e_vec64, want);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        instrD = I_MUL; validD = 1'b1;
        @(negedge clk);
        validD = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (e_vec !== E_BUB) begin
            mismatched++; $display("[TB] FAIL async_reset_e: got %b want %b", e_vec, E_BUB);
        end
        compared++;
        if (readyD !== 1'b0) begin
            mismatched++; $display("[TB] FAIL async_reset_ready: got %b want 0", readyD);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compared++;
        if (readyD !== 1'b1) begin
            mismatched++; $display("[TB] FAIL reset_idle_ready: got %b want 1", readyD);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_decode();
        test_muldiv();
        test_stall();
        test_flush();
        test_wordop();
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
